multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle main controller for the RV32 core. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives per-state datapath controls. It stalls on a shared-memory ready handshake and traps on illegal opcodes or memory timeouts. It sits between the instruction register and the datapath, replacing single-cycle opcode decode when the core runs with a single unified memory port.

## Interface
- `MEM_TIMEOUT`, default 16: maximum wait cycles on `mem_ready` before a timeout trap; 0 disables the timeout.
- `EN_JALR`, default 1: when 1, opcode 1100111 is legal; when 0, it is illegal.
- `EN_AUIPC`, default 1: when 1, opcode 0010111 is legal; when 0, it is illegal.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: start/continue request, sampled only in IDLE.
- `opcode` in 7: `instr[6:0]` from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `mem_read` out 1: memory read request (fetch or load).
- `mem_write` out 1: memory write request (store).
- `iord` out 1: memory address select; 0 = PC, 1 = ALU result.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: unconditional PC update.
- `branch` out 1: conditional PC update, qualified by ALU zero in the datapath.
- `jump` out 1: PC gets the jump target.
- `alu_src_a` out 2: ALU A select; 00 = rs1, 01 = PC, 10 = zero.
- `alu_src` out 1: ALU B select; 0 = rs2, 1 = immediate.
- `alu_op` out 2: ALU operation; 00 = add, 01 = sub/compare, 10 = R-type funct, 11 = I-type/LUI.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: writeback source; 00 = ALU, 01 = memory, 10 = PC+4.
- `trap` out 1: sticky halt indicator.
- `trap_cause` out 2: 01 = illegal opcode, 10 = memory timeout.
- `state` out 3: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset state is IDLE. In IDLE and TRAP, every control output is 0 except `trap` and `trap_cause`.
- The opcode is registered at the end of DECODE. EXEC, MEM and WB use the registered copy.

Per-state behaviour:
- IDLE: go to FETCH when `en`=1; otherwise stay in IDLE.
- FETCH: drive `mem_read`=1, `iord`=0.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+4) in that same cycle, then go to DECODE.
  - `ir_write` and `pc_write` are Mealy outputs on `mem_ready`.
- DECODE: one cycle, no controls asserted. Legal opcode goes to EXEC; illegal opcode goes to TRAP with cause 01.
- EXEC, by opcode class:
  - R-type: `alu_op`=10 → WB.
  - I-type: `alu_src`=1, `alu_op`=11 → WB.
  - LUI: `alu_src_a`=10, `alu_src`=1, `alu_op`=11 → WB.
  - AUIPC: `alu_src_a`=01, `alu_src`=1, `alu_op`=00 → WB.
  - Load/Store: `alu_src`=1, `alu_op`=00 → MEM.
  - Branch: `branch`=1, `alu_op`=01 → FETCH.
  - JAL: `jump`=1 → WB.
  - JALR: `jump`=1, `alu_src`=1, `alu_op`=00 → WB.
- MEM: `iord`=1.
  - Load: `mem_read`=1; on `mem_ready` go to WB.
  - Store: `mem_write`=1; on `mem_ready` go to FETCH.
- WB: `reg_write`=1 for one cycle → FETCH.
  - `wb_sel`: 01 for load, 10 for JAL/JALR, 00 otherwise.
- TRAP: absorbing state; only `rst_n` exits it.

Wait counter:
- Width is clog2(`MEM_TIMEOUT`+1). It clears on entry to FETCH or MEM.
- It increments each FETCH/MEM cycle that has `mem_ready`=0.
- If it already equals `MEM_TIMEOUT`-1 and `mem_ready`=0, go to TRAP with cause 10.
- If `mem_ready` is 1 in that same cycle, completion wins and no trap occurs.

## Timing
Latency with zero-wait memory (`mem_ready` tied high), counted from entering FETCH:
- Branch: 3 cycles.
- R-type, I-type, LUI, AUIPC, JAL, JALR and store: 4 cycles.
- Load: 5 cycles.
- Each cycle of `mem_ready`=0 adds exactly one cycle.

Other timing rules:
- Memory request signals are held stable until the cycle `mem_ready` is seen.
- `en` is ignored outside IDLE.
- When `rst_n` is asserted mid-operation, state goes to IDLE immediately (asynchronously) and all outputs go to 0, including `trap` and `trap_cause`.
- The first FETCH after reset release occurs no earlier than the second rising edge.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - opcode localparams;
  - the `ctrl_state_t` enum;
  - the `alu_op`, `alu_src_a`, `wb_sel` and `trap_cause` encodings;
  - the `opc_class_t` enum.
- Sub-module `opcode_classifier` is purely combinational: opcode plus `EN_*` parameters → class and legal flag.
- The FSM, wait counter and output decode live in the top module.

## Test plan
- Zero-wait `mem_ready`; run R-type 0110011 → `reg_write`=1 exactly in cycle 4, `wb_sel`=00, back in FETCH at cycle 5.
- Load 0000011 with `mem_ready` low 3 cycles in MEM → WB entered at cycle 8, `wb_sel`=01, `mem_read` held stable across the waits.
- Branch 1100011 → `branch`=1 only in cycle 3, no `reg_write` at any point, next FETCH at cycle 4.
- `EN_JALR`=0 and opcode 1100111 → TRAP after DECODE, `trap`=1, `trap_cause`=01, held 100 cycles until `rst_n` low clears all outputs.
- `MEM_TIMEOUT`=4 with `mem_ready` held low in FETCH → TRAP cause 10 after exactly 4 wait cycles; a repeat run with `mem_ready`=1 in the 4th cycle completes with no trap.
- `rst_n` pulsed low during MEM of a store → `mem_write` drops in the same cycle, state = IDLE, no write occurs after release until `en`.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 main controller: opcodes,
// FSM states, datapath select codes and the opcode class enum.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_LOAD   = 4'd4,
    CLS_STORE  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_NONE   = 4'd9
  } opc_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: maps a 7-bit major opcode to its class and
// a legal flag, honouring the optional-instruction enables.
module opcode_classifier
  import rv_ctrl_pkg::*;
#(
  parameter int EN_JALR  = 1,
  parameter int EN_AUIPC = 1
) (
  input  logic [6:0] opcode,
  output logic [3:0] opc_class,
  output logic       legal
);

  opc_class_t cls;

  // Classify the opcode; anything unrecognised or disabled is CLS_NONE.
  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OPC_R_TYPE: cls = CLS_R;
      OPC_I_TYPE: cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LUI:    cls = CLS_LUI;
      OPC_JAL:    cls = CLS_JAL;
      OPC_AUIPC:  cls = (EN_AUIPC != 0) ? CLS_AUIPC : CLS_NONE;
      OPC_JALR:   cls = (EN_JALR != 0) ? CLS_JALR : CLS_NONE;
      default:    cls = CLS_NONE;
    endcase
  end

  assign opc_class = cls;
  assign legal     = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// per-state datapath controls, stalls on mem_ready and traps on illegal
// opcodes or memory timeouts.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_JALR     = 1,
  parameter int EN_AUIPC    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_src_a,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  ctrl_state_t state_reg, state_next;
  logic [6:0]  opc_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [1:0]  cause_reg, cause_next;
  logic        rst_done_reg;   // blocks leaving IDLE on the first edge after reset release

  logic [6:0]  cls_opcode;
  logic [3:0]  cls_bits;
  opc_class_t  cur_cls;
  logic        cur_legal;
  logic        mem_wait;
  logic        timeout_hit;

  // DECODE judges the live opcode; later states use the copy latched at the end of DECODE.
  assign cls_opcode = (state_reg == ST_DECODE) ? opcode : opc_reg;

  opcode_classifier #(
    .EN_JALR  (EN_JALR),
    .EN_AUIPC (EN_AUIPC)
  ) u_classifier (
    .opcode    (cls_opcode),
    .opc_class (cls_bits),
    .legal     (cur_legal)
  );

  assign cur_cls  = opc_class_t'(cls_bits);
  assign mem_wait = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = mem_wait && (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State, latched opcode, trap cause and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      opc_reg      <= '0;
      wait_cnt_reg <= '0;
      cause_reg    <= CAUSE_NONE;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cause_reg    <= cause_next;
      rst_done_reg <= 1'b1;
      if (state_reg == ST_DECODE) begin
        opc_reg <= opcode;
      end
      if ((state_next != state_reg) &&
          ((state_next == ST_FETCH) || (state_next == ST_MEM))) begin
        wait_cnt_reg <= '0;
      end else if (mem_wait) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Next-state and per-state control decode; completion beats timeout.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_src_a  = SRC_A_RS1;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    case (state_reg)
      ST_IDLE: begin
        if (en && rst_done_reg) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (cur_legal) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        state_next = ST_WB;
        case (cur_cls)
          CLS_R:     alu_op = ALU_FUNCT;
          CLS_I:     begin alu_src = 1'b1; alu_op = ALU_IMM; end
          CLS_LUI:   begin alu_src_a = SRC_A_ZERO; alu_src = 1'b1; alu_op = ALU_IMM; end
          CLS_AUIPC: begin alu_src_a = SRC_A_PC; alu_src = 1'b1; alu_op = ALU_ADD; end
          CLS_LOAD, CLS_STORE: begin
            alu_src    = 1'b1;
            state_next = ST_MEM;
          end
          CLS_BRANCH: begin
            branch     = 1'b1;
            alu_op     = ALU_SUB;
            state_next = ST_FETCH;
          end
          CLS_JAL:   jump = 1'b1;
          CLS_JALR:  begin jump = 1'b1; alu_src = 1'b1; end
          default: begin
            state_next = ST_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        iord      = 1'b1;
        mem_write = (cur_cls == CLS_STORE);
        mem_read  = (cur_cls != CLS_STORE);
        if (mem_ready) begin
          state_next = (cur_cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        state_next = ST_FETCH;
        if (cur_cls == CLS_LOAD) wb_sel = WB_MEM;
        else if ((cur_cls == CLS_JAL) || (cur_cls == CLS_JALR)) wb_sel = WB_PC4;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign trap       = (state_reg == ST_TRAP);
  assign trap_cause = cause_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction cycle
// script derived from the controller rules predicts every output each cycle.
module tb_multicycle_control_fsm;

  localparam int T_TIMEOUT  = 4;
  localparam int T_EN_JALR  = 0;
  localparam int T_EN_AUIPC = 1;

  // Bench-side instruction kinds.
  localparam int K_ILL = -1, K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_LOAD = 4,
                 K_STORE = 5, K_BRANCH = 6, K_JAL = 7, K_JALR = 8;

  // Bit masks of the observed control vector.
  localparam logic [17:0] M_MR   = 18'h20000;
  localparam logic [17:0] M_MW   = 18'h10000;
  localparam logic [17:0] M_IORD = 18'h08000;
  localparam logic [17:0] M_IRW  = 18'h04000;
  localparam logic [17:0] M_PCW  = 18'h02000;
  localparam logic [17:0] M_BR   = 18'h01000;
  localparam logic [17:0] M_JMP  = 18'h00800;
  localparam logic [17:0] M_ASRC = 18'h00100;
  localparam logic [17:0] M_RW   = 18'h00020;
  localparam logic [17:0] M_TRAP = 18'h00004;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch, jump;
  logic [1:0] alu_src_a, alu_op, wb_sel, trap_cause;
  logic       alu_src, reg_write, trap;
  logic [2:0] state;
  logic [17:0] obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .MEM_TIMEOUT (T_TIMEOUT),
    .EN_JALR     (T_EN_JALR),
    .EN_AUIPC    (T_EN_AUIPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .jump       (jump),
    .alu_src_a  (alu_src_a),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state      (state)
  );

  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, branch, jump,
                alu_src_a, alu_src, alu_op, reg_write, wb_sel, trap, trap_cause};

  task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] fld(input logic [1:0] v, input int sh);
    return 18'(v) << sh;
  endfunction

  function automatic logic [6:0] rj();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0110111: return K_LUI;
      7'b0010111: return (T_EN_AUIPC != 0) ? K_AUIPC : K_ILL;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return (T_EN_JALR != 0) ? K_JALR : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [6:0] pick_opc(input int i);
    case (i)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0110111;
      3: return 7'b0010111;
      4: return 7'b0000011;
      5: return 7'b0100011;
      6: return 7'b1100011;
      7: return 7'b1101111;
      8: return 7'b1100111;
      default: return 7'($urandom);
    endcase
  endfunction

  // Expected EXEC-cycle controls for each instruction kind.
  function automatic logic [17:0] exec_vec(input int k);
    case (k)
      K_R:      return fld(2'b10, 6);
      K_I:      return M_ASRC | fld(2'b11, 6);
      K_LUI:    return fld(2'b10, 9) | M_ASRC | fld(2'b11, 6);
      K_AUIPC:  return fld(2'b01, 9) | M_ASRC;
      K_LOAD:   return M_ASRC;
      K_STORE:  return M_ASRC;
      K_BRANCH: return M_BR | fld(2'b01, 6);
      K_JAL:    return M_JMP;
      K_JALR:   return M_JMP | M_ASRC;
      default:  return 18'h0;
    endcase
  endfunction

  // One clock cycle: drive inputs on the falling edge, then sample.
  task automatic step(input logic rdy, input logic [6:0] opc, input logic e,
                      input string tag, input logic [17:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = opc;
    en        = e;
    #1 check_vec(tag, obs, exp);
  endtask

  // Memory handshake phase with a given number of not-ready cycles.
  task automatic mem_phase(input int waits, input logic [17:0] base, input logic [17:0] done_extra,
                           input string tag, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (i < waits) begin
        step(1'b0, rj(), rb(), tag, base);
        if (i == T_TIMEOUT - 1) begin
          timed_out = 1'b1;
          return;
        end
      end else begin
        step(1'b1, rj(), rb(), tag, base | done_extra);
      end
    end
  endtask

  task automatic trap_phase(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++) step(rb(), rj(), rb(), "trap_hold", M_TRAP | fld(cause, 0));
  endtask

  // Full instruction from FETCH through its last state.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                           input int trap_len, output bit trapped);
    bit to;
    int k;
    trapped = 1'b0;
    mem_phase(fw, M_MR, M_IRW | M_PCW, "fetch", to);
    if (to) begin trap_phase(2'b10, trap_len); trapped = 1'b1; return; end
    step(rb(), opc, rb(), "decode", 18'h0);
    k = kind_of(opc);
    if (k == K_ILL) begin trap_phase(2'b01, trap_len); trapped = 1'b1; return; end
    step(rb(), rj(), rb(), "exec", exec_vec(k));
    if (k == K_LOAD || k == K_STORE) begin
      mem_phase(mw, M_IORD | ((k == K_STORE) ? M_MW : M_MR), 18'h0, "mem", to);
      if (to) begin trap_phase(2'b10, trap_len); trapped = 1'b1; return; end
      if (k == K_STORE) return;
    end
    if (k == K_BRANCH) return;
    step(rb(), rj(), rb(), "wb",
         M_RW | fld((k == K_LOAD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00), 3));
  endtask

  // Release reset and bring the controller to the cycle before FETCH.
  task automatic release_and_start(input bit immediate);
    rst_n = 1'b1;
    en    = immediate;
    if (immediate) begin
      step(rb(), rj(), 1'b1, "release_idle", 18'h0);
    end else begin
      step(rb(), rj(), 1'b0, "idle_no_en", 18'h0);
      step(rb(), rj(), 1'b0, "idle_no_en", 18'h0);
      step(rb(), rj(), 1'b1, "idle_en", 18'h0);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_vec("reset_async", obs, 18'h0);
    @(negedge clk);
    check_vec("reset_hold", obs, 18'h0);
  endtask

  initial begin
    bit tr;
    bit to;
    int fw, mw;
    repeat (2) @(negedge clk);
    #1 check_vec("reset_state", obs, 18'h0);
    release_and_start(1'b1);

    // Directed: R-type, load with 3 waits, branch, all zero-wait fetch.
    run_instr(7'b0110011, 0, 0, 0, tr);
    run_instr(7'b0000011, 0, 3, 0, tr);
    run_instr(7'b1100011, 0, 0, 0, tr);

    // Disabled JALR traps with cause 01 and holds.
    run_instr(7'b1100111, 0, 0, 100, tr);
    check_vec("jalr_trapped", {17'h0, tr}, 18'h1);
    async_reset();
    release_and_start(1'b0);

    // Timeout after exactly T_TIMEOUT waits, then completion on the last allowed cycle.
    run_instr(7'b0110011, T_TIMEOUT, 0, 5, tr);
    check_vec("timeout_trapped", {17'h0, tr}, 18'h1);
    async_reset();
    release_and_start(1'b0);
    run_instr(7'b0110011, T_TIMEOUT - 1, 0, 0, tr);
    check_vec("late_ready_no_trap", {17'h0, tr}, 18'h0);

    // Reset during the MEM cycle of a store.
    mem_phase(0, M_MR, M_IRW | M_PCW, "fetch", to);
    step(rb(), 7'b0100011, rb(), "decode", 18'h0);
    step(rb(), rj(), rb(), "exec", exec_vec(K_STORE));
    step(1'b0, rj(), 1'b0, "mem_store", M_IORD | M_MW);
    async_reset();
    release_and_start(1'b0);

    // Randomized instruction stream with occasional long waits.
    for (int n = 0; n < 250; n++) begin
      fw = ($urandom_range(0, 11) == 0) ? T_TIMEOUT + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 11) == 0) ? T_TIMEOUT + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      run_instr(pick_opc(int'($urandom_range(0, 9))), fw, mw, int'($urandom_range(1, 4)), tr);
      if (tr) begin
        async_reset();
        release_and_start(bit'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
